fibonacci_decoder: RTL and testbench

Downstream stage of the Fibonacci random encoder. It takes the 128-bit Fibonacci-weighted representation and reconstructs the 64-bit binary value; it is used for round-trip and avalanche checking of the obfuscation path. It is a sequential bit-serial decoder that reads Fibonacci weights as 16-bit words from the shared Fibonacci table ROM. The ROM is combinational: address in, data out in the same cycle.

---
 rtl/fib_codec_pkg.sv | 18 +
 rtl/fibonacci_decoder_if.sv | 23 ++
 rtl/fib_chunk_acc.sv | 16 +
 rtl/fibonacci_decoder.sv | 84 ++++++++
 tb/tb_fibonacci_decoder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fib_codec_pkg.sv
// Shared constants and state encoding for the Fibonacci encoder/decoder pair.
package fib_codec_pkg;

    localparam int unsigned N_BITS        = 128;
    localparam int unsigned OUT_W         = 64;
    localparam int unsigned WORD_W        = 16;
    localparam int unsigned ADDR_W        = 10;
    localparam int unsigned WORDS_PER_FIB = 4;
    localparam int unsigned IDX_W         = $clog2(N_BITS);
    localparam int unsigned K_W           = $clog2(WORDS_PER_FIB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FETCH = 2'd2
    } state_t;

endpackage

// File: rtl/fibonacci_decoder_if.sv
// Start/result handshake and ROM port of the Fibonacci decoder.
interface fibonacci_decoder_if;
    import fib_codec_pkg::*;

    logic              en_decode;
    logic [N_BITS-1:0] fibonacci_random;
    logic [ADDR_W-1:0] cnt_a;
    logic [WORD_W-1:0] mema;
    logic [OUT_W-1:0]  output_binary;
    logic              decode_done;
    logic              busy;

    modport master (
        output en_decode, fibonacci_random, mema,
        input  cnt_a, output_binary, decode_done, busy
    );

    modport slave (
        input  en_decode, fibonacci_random, mema,
        output cnt_a, output_binary, decode_done, busy
    );

endinterface

// File: rtl/fib_chunk_acc.sv
// Adds one 16-bit ROM word, placed at chunk position k, into the 64-bit accumulator.
module fib_chunk_acc
    import fib_codec_pkg::*;
(
    input  logic [OUT_W-1:0]  acc_in,
    input  logic [WORD_W-1:0] word,
    input  logic [K_W-1:0]    k,
    output logic [OUT_W-1:0]  acc_out
);

    logic [5:0] shamt;

    assign shamt   = {k, 4'd0};
    assign acc_out = acc_in + (OUT_W'(word) << shamt);

endmodule

// File: rtl/fibonacci_decoder.sv
// Bit-serial Fibonacci-to-binary decoder; sums ROM weights of the set code bits.
module fibonacci_decoder
    import fib_codec_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fibonacci_decoder_if.slave bus
);

    state_t            state;
    logic [N_BITS-1:0] code;
    logic [IDX_W-1:0]  i;
    logic [K_W-1:0]    k;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_next;
    logic              last_bit;

    assign last_bit  = (i == IDX_W'(N_BITS - 1));
    assign bus.cnt_a = (state == FETCH) ? ADDR_W'({i, k}) : '0;

    fib_chunk_acc u_chunk_acc (
        .acc_in  (acc),
        .word    (bus.mema),
        .k       (k),
        .acc_out (acc_next)
    );

    // Control FSM: SCAN walks the code bits, FETCH accumulates the four weight words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            code              <= '0;
            i                 <= '0;
            k                 <= '0;
            acc               <= '0;
            bus.output_binary <= '0;
            bus.decode_done   <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            bus.decode_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en_decode) begin
                        code     <= bus.fibonacci_random;
                        acc      <= '0;
                        i        <= '0;
                        bus.busy <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (code[i]) begin
                        k     <= '0;
                        state <= FETCH;
                    end else if (!last_bit) begin
                        i <= i + IDX_W'(1);
                    end else begin
                        bus.output_binary <= acc;
                        bus.decode_done   <= 1'b1;
                        bus.busy          <= 1'b0;
                        state             <= IDLE;
                    end
                end
                FETCH: begin
                    acc <= acc_next;
                    if (k != K_W'(WORDS_PER_FIB - 1)) begin
                        k <= k + K_W'(1);
                    end else if (!last_bit) begin
                        i     <= i + IDX_W'(1);
                        state <= SCAN;
                    end else begin
                        // Last weight word: publish the sum including this word.
                        bus.output_binary <= acc_next;
                        bus.decode_done   <= 1'b1;
                        bus.busy          <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_decoder.sv
// Randomized self-checking bench for fibonacci_decoder with a cycle-level reference model.
module tb_fibonacci_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fibonacci_decoder_if bus ();

    fibonacci_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] fib [0:127];
    logic [15:0] rom [0:1023];

    assign bus.mema = rom[bus.cnt_a];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Weighted sum of the set bits, wrapping mod 2^64.
    function automatic logic [63:0] ref_decode(input logic [127:0] c);
        logic [63:0] s = '0;
        for (int n = 0; n < 128; n++)
            if (c[n]) s = s + fib[n];
        return s;
    endfunction

    // Greedy Zeckendorf encoding; F(93) is the largest weight below 2^64.
    function automatic logic [127:0] zeck(input logic [63:0] v);
        logic [127:0] c   = '0;
        logic [63:0]  rem = v;
        for (int n = 91; n >= 0; n--)
            if (fib[n] <= rem) begin
                c[n] = 1'b1;
                rem  = rem - fib[n];
            end
        return c;
    endfunction

    // Reference model: per-cycle expected cnt_a schedule, busy/done and result.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [63:0] m_out  = '0;
    logic [63:0] m_val  = '0;
    int          m_e    = 0;
    int          m_sched [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_out  = '0;
            m_e    = 0;
        end else if (m_busy) begin
            m_e++;
            if (m_e == m_sched.size()) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_out  = m_val;
            end
        end else begin
            m_done = 1'b0;
            if (bus.en_decode) begin
                m_sched.delete();
                for (int n = 0; n < 128; n++) begin
                    m_sched.push_back(0);
                    if (bus.fibonacci_random[n])
                        for (int q = 0; q < 4; q++) m_sched.push_back(4 * n + q);
                end
                m_val  = ref_decode(bus.fibonacci_random);
                m_busy = 1'b1;
                m_e    = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("decode_done", 64'(bus.decode_done), 64'(m_done));
        chk("cnt_a", 64'(bus.cnt_a), m_busy ? 64'(m_sched[m_e]) : 64'd0);
        chk("output_binary", bus.output_binary, m_out);
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.decode_done && lat < 700) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.decode_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no decode_done after %0d cycles required <= 640", lat);
        end
    endtask

    task automatic run_code(input logic [127:0] c, output logic [63:0] res, output int lat);
        @(negedge clk);
        bus.fibonacci_random = c;
        bus.en_decode        = 1'b1;
        @(negedge clk);
        bus.en_decode = 1'b0;
        wait_done(lat);
        res = bus.output_binary;
    endtask

    initial begin
        logic [63:0]  res;
        logic [63:0]  f1;
        logic [63:0]  f2;
        logic [63:0]  ft;
        logic [63:0]  v;
        logic [127:0] c;
        logic [127:0] c_a;
        int           lat;

        fib[0] = 64'd1;
        fib[1] = 64'd2;
        for (int n = 2; n < 128; n++) fib[n] = fib[n-1] + fib[n-2];
        for (int a = 0; a < 1024; a++) rom[a] = '0;
        for (int n = 0; n < 128; n++)
            for (int q = 0; q < 4; q++) rom[4*n+q] = fib[n][16*q +: 16];

        // Independent pin for the all-ones case: F(131) - 2 mod 2^64.
        f1 = 64'd1;
        f2 = 64'd1;
        for (int n = 3; n <= 131; n++) begin
            ft = f1 + f2;
            f1 = f2;
            f2 = ft;
        end

        bus.en_decode        = 1'b0;
        bus.fibonacci_random = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_code(128'h0, res, lat);
        chk("zero_val", res, 64'd0);
        chk("zero_lat", 64'(lat), 64'd128);

        run_code(128'h1, res, lat);
        chk("one_val", res, 64'd1);
        chk("one_lat", 64'(lat), 64'd132);

        c = '0;
        c[9] = 1'b1; c[4] = 1'b1; c[2] = 1'b1;
        run_code(c, res, lat);
        chk("hundred_val", res, 64'd100);
        chk("hundred_lat", 64'(lat), 64'd140);

        run_code(128'h7, res, lat);
        chk("noncanon_val", res, 64'd6);
        chk("noncanon_lat", 64'(lat), 64'd140);

        run_code({128{1'b1}}, res, lat);
        chk("ones_val", res, f2 - 64'd2);
        chk("ones_lat", 64'(lat), 64'd640);

        // Mid-run disturbance of en_decode and fibonacci_random.
        c_a = c;
        @(negedge clk);
        bus.fibonacci_random = c_a;
        bus.en_decode        = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 20; n++) begin
            bus.en_decode        = 1'($urandom);
            bus.fibonacci_random = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        bus.en_decode = 1'b0;
        wait_done(lat);
        chk("disturb_val", bus.output_binary, 64'd100);
        chk("disturb_lat", 64'(lat + 20), 64'd140);

        // Asynchronous reset in the middle of a long decode.
        @(negedge clk);
        bus.fibonacci_random = {128{1'b1}};
        bus.en_decode        = 1'b1;
        @(negedge clk);
        bus.en_decode = 1'b0;
        repeat (49) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.decode_done), 64'd0);
        chk("rst_cnt_a", 64'(bus.cnt_a), 64'd0);
        chk("rst_out", bus.output_binary, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        run_code(128'h7, res, lat);
        chk("post_rst_val", res, 64'd6);
        chk("post_rst_lat", 64'(lat), 64'd140);

        // en_decode held high: ignored on the done edge, accepted on the next one.
        @(negedge clk);
        bus.fibonacci_random = '0;
        bus.en_decode        = 1'b1;
        @(negedge clk);
        wait_done(lat);
        chk("b2b_lat", 64'(lat), 64'd128);
        chk("b2b_idle_busy", 64'(bus.busy), 64'd0);
        bus.fibonacci_random = 128'h1;
        @(negedge clk);
        bus.en_decode = 1'b0;
        chk("b2b_restart_busy", 64'(bus.busy), 64'd1);
        chk("b2b_restart_done", 64'(bus.decode_done), 64'd0);
        wait_done(lat);
        chk("b2b_val", bus.output_binary, 64'd1);
        chk("b2b_lat2", 64'(lat), 64'd132);

        // Random raw codes of varying density, including non-canonical patterns.
        for (int t = 0; t < 25; t++) begin
            c = {$urandom, $urandom, $urandom, $urandom};
            if (t % 2 == 0) c = c & {$urandom, $urandom, $urandom, $urandom};
            run_code(c, res, lat);
            chk("rand_val", res, ref_decode(c));
            chk("rand_lat", 64'(lat), 64'(128 + 4 * $countones(c)));
        end

        // Round trip through a Zeckendorf encoder sharing the same ROM weights.
        for (int t = 0; t < 120; t++) begin
            v = {$urandom, $urandom};
            if (t == 0) v = '0;
            if (t == 1) v = '1;
            c = zeck(v);
            run_code(c, res, lat);
            chk("roundtrip_val", res, v);
            chk("roundtrip_lat", 64'(lat), 64'(128 + 4 * $countones(c)));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
